// File: rtl/x2_bist_pkg.sv
// Shared types and constants for the x2 BIST response-compaction path.
package x2_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned RESP_W = 7;

    // Bit positions of the x2 outputs k..q within a response beat.
    localparam int unsigned K = 0;
    localparam int unsigned L = 1;
    localparam int unsigned M = 2;
    localparam int unsigned N = 3;
    localparam int unsigned O = 4;
    localparam int unsigned P = 5;
    localparam int unsigned Q = 6;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'h0000;

endpackage

// File: rtl/x2_misr_step.sv
// Combinational MISR update: shift left, fold in polynomial on MSB, XOR in response.
module x2_misr_step
    import x2_bist_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
    input  logic [SIG_W-1:0]  sig,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig_next_c
);

    logic [SIG_W-1:0] fb;

    always_comb begin
        fb         = sig[SIG_W-1] ? POLY : '0;
        sig_next_c = {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(resp);
    end

endmodule

// File: rtl/x2_resp_misr.sv
// Response compaction stage: folds x2 response beats into a MISR and compares
// the final signature against an expected value after a programmed beat count.
module x2_resp_misr
    import x2_bist_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED),
    parameter int unsigned      CNT_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  vec_total,
    input  logic [SIG_W-1:0]  exp_sig,
    input  logic              resp_valid,
    input  logic [RESP_W-1:0] resp,
    output logic              resp_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  resp_count
);

    state_e           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [SIG_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             pass_q, pass_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SIG_W-1:0] sig_next_c;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    x2_misr_step #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_step (
        .sig        (sig_q),
        .resp       (resp),
        .sig_next_c (sig_next_c)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        pass_d  = pass_q;
        accept  = resp_valid & ready_q;
        cnt_inc = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    total_d = vec_total;
                    exp_d   = exp_sig;
                    if (vec_total != '0) begin
                        pass_d  = 1'b0;
                        state_d = RUN;
                    end else begin
                        pass_d  = (SEED == exp_sig);
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    sig_d = sig_next_c;
                    cnt_d = cnt_inc;
                    if (cnt_inc == total_q) begin
                        pass_d  = (sig_next_c == exp_q);
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == RUN);
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            exp_q   <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            pass_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            pass_q  <= pass_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign resp_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign resp_count = cnt_q;

endmodule

// File: tb/tb_x2_resp_misr.sv
// Directed bench for x2_resp_misr: default-seed instance plus a SEED=16'h8000 instance.
module tb_x2_resp_misr;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [10:0] vec_total;
    logic [15:0] exp_sig;
    logic        resp_valid;
    logic [6:0]  resp;

    logic        resp_ready, busy, done, pass;
    logic [15:0] signature;
    logic [10:0] resp_count;

    logic        fb_ready, fb_busy, fb_done, fb_pass;
    logic [15:0] fb_signature;
    logic [10:0] fb_count;

    int checks = 0;
    int errors = 0;

    x2_resp_misr dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vec_total  (vec_total),
        .exp_sig    (exp_sig),
        .resp_valid (resp_valid),
        .resp       (resp),
        .resp_ready (resp_ready),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .resp_count (resp_count)
    );

    x2_resp_misr #(.SEED(16'h8000)) dut_fb (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vec_total  (vec_total),
        .exp_sig    (exp_sig),
        .resp_valid (resp_valid),
        .resp       (resp),
        .resp_ready (fb_ready),
        .busy       (fb_busy),
        .done       (fb_done),
        .pass       (fb_pass),
        .signature  (fb_signature),
        .resp_count (fb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [10:0] tot, input logic [15:0] e);
        start     = 1'b1;
        vec_total = tot;
        exp_sig   = e;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({resp_ready, busy, done, pass} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {resp_ready, busy, done, pass});
        end
        checks++;
        if (signature !== 16'h0000 || resp_count !== 11'd0) begin
            errors++;
            $display("FAIL reset_sig_cnt: got %h/%0d want 0000/0", signature, resp_count);
        end
        checks++;
        if (fb_signature !== 16'h8000) begin
            errors++;
            $display("FAIL reset_fb_seed: got %h want 8000", fb_signature);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_two_beats();
        do_start(11'd2, 16'h0000);
        checks++;
        if ({busy, resp_ready, done} !== 3'b110 || resp_count !== 11'd0) begin
            errors++;
            $display("FAIL two_run_entry: got busy/ready/done=%b cnt=%0d want 110 cnt=0",
                     {busy, resp_ready, done}, resp_count);
        end
        resp_valid = 1'b1;
        resp       = 7'h01;
        tick();
        checks++;
        if (signature !== 16'h0001 || resp_count !== 11'd1 || done !== 1'b0) begin
            errors++;
            $display("FAIL two_beat1: got sig=%h cnt=%0d done=%b want 0001 1 0",
                     signature, resp_count, done);
        end
        resp = 7'h02;
        tick();
        resp_valid = 1'b0;
        checks++;
        if (signature !== 16'h0000 || resp_count !== 11'd2) begin
            errors++;
            $display("FAIL two_beat2: got sig=%h cnt=%0d want 0000 2", signature, resp_count);
        end
        checks++;
        if ({done, pass, busy, resp_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL two_done: got done/pass/busy/ready=%b want 1100",
                     {done, pass, busy, resp_ready});
        end
    endtask

    task automatic test_feedback();
        do_start(11'd1, 16'h1021);
        resp_valid = 1'b1;
        resp       = 7'h00;
        tick();
        resp_valid = 1'b0;
        checks++;
        if (fb_signature !== 16'h1021 || fb_done !== 1'b1 || fb_pass !== 1'b1) begin
            errors++;
            $display("FAIL feedback_fb: got sig=%h done=%b pass=%b want 1021 1 1",
                     fb_signature, fb_done, fb_pass);
        end
        checks++;
        if (signature !== 16'h0000 || pass !== 1'b0) begin
            errors++;
            $display("FAIL feedback_noseed: got sig=%h pass=%b want 0000 0", signature, pass);
        end
    endtask

    task automatic test_mismatch();
        do_start(11'd1, 16'h0000);
        resp_valid = 1'b1;
        resp       = 7'h7F;
        tick();
        resp_valid = 1'b0;
        checks++;
        if (signature !== 16'h007F || done !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL mismatch: got sig=%h done=%b pass=%b want 007f 1 0",
                     signature, done, pass);
        end
    endtask

    task automatic test_stall_backpressure();
        do_start(11'd3, 16'h0006);
        resp_valid = 1'b1;
        resp       = 7'h01;
        tick();
        resp_valid = 1'b0;
        resp       = 7'h7F;
        start      = 1'b1;
        vec_total  = 11'd0;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (signature !== 16'h0001 || resp_count !== 11'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got sig=%h cnt=%0d busy=%b want 0001 1 1",
                     signature, resp_count, busy);
        end
        resp_valid = 1'b1;
        resp       = 7'h03;
        tick();
        resp_valid = 1'b0;
        checks++;
        if (signature !== 16'h0001 || resp_count !== 11'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_beat2: got sig=%h cnt=%0d busy=%b want 0001 2 1",
                     signature, resp_count, busy);
        end
        resp_valid = 1'b1;
        resp       = 7'h04;
        tick();
        checks++;
        if (signature !== 16'h0006 || resp_count !== 11'd3 || {done, pass} !== 2'b11) begin
            errors++;
            $display("FAIL stall_last: got sig=%h cnt=%0d done/pass=%b want 0006 3 11",
                     signature, resp_count, {done, pass});
        end
        resp = 7'h7F;
        tick();
        tick();
        resp_valid = 1'b0;
        checks++;
        if (resp_ready !== 1'b0 || signature !== 16'h0006 || resp_count !== 11'd3 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_backpressure: got ready=%b sig=%h cnt=%0d done=%b want 0 0006 3 1",
                     resp_ready, signature, resp_count, done);
        end
    endtask

    task automatic test_zero_restart();
        do_start(11'd0, 16'h0000);
        checks++;
        if ({done, pass, busy} !== 3'b110 || signature !== 16'h0000 || resp_count !== 11'd0) begin
            errors++;
            $display("FAIL zero_pass: got done/pass/busy=%b sig=%h cnt=%0d want 110 0000 0",
                     {done, pass, busy}, signature, resp_count);
        end
        do_start(11'd0, 16'h0005);
        checks++;
        if ({done, pass} !== 2'b10) begin
            errors++;
            $display("FAIL zero_fail: got done/pass=%b want 10", {done, pass});
        end
        do_start(11'd2, 16'h0000);
        checks++;
        if ({busy, done, pass} !== 3'b100 || signature !== 16'h0000 || resp_count !== 11'd0) begin
            errors++;
            $display("FAIL restart: got busy/done/pass=%b sig=%h cnt=%0d want 100 0000 0",
                     {busy, done, pass}, signature, resp_count);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [6:0] beats [3];
        beats[0] = 7'h01;
        beats[1] = 7'h02;
        beats[2] = 7'h04;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        do_start(11'd5, 16'h0000);
        resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            resp = beats[i];
            tick();
        end
        resp_valid = 1'b0;
        checks++;
        if (signature !== 16'h0004 || resp_count !== 11'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort: got sig=%h cnt=%0d busy=%b want 0004 3 1",
                     signature, resp_count, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, resp_ready} !== 4'b0000 || signature !== 16'h0000 || resp_count !== 11'd0) begin
            errors++;
            $display("FAIL abort: got flags=%b sig=%h cnt=%0d want 0000 0000 0",
                     {busy, done, pass, resp_ready}, signature, resp_count);
        end
        checks++;
        if (fb_signature !== 16'h8000 || fb_count !== 11'd0) begin
            errors++;
            $display("FAIL abort_fb: got sig=%h cnt=%0d want 8000 0", fb_signature, fb_count);
        end
        tick();
        rst_n      = 1'b1;
        resp_valid = 1'b1;
        resp       = 7'h55;
        tick();
        tick();
        resp_valid = 1'b0;
        checks++;
        if (resp_ready !== 1'b0 || signature !== 16'h0000 || resp_count !== 11'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_backpressure: got ready=%b sig=%h cnt=%0d busy=%b want 0 0000 0 0",
                     resp_ready, signature, resp_count, busy);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        vec_total  = '0;
        exp_sig    = '0;
        resp_valid = 1'b0;
        resp       = '0;

        test_reset();
        test_two_beats();
        test_feedback();
        test_mismatch();
        test_stall_backpressure();
        test_zero_restart();
        test_reset_mid_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
